// File: rtl/bfs_pkg.sv
// Shared BFS types and widths.
//   node_state_t : per-node state stored in the node-state RAM {parent, active}
//   NODEID_W     : node identifier width
//   LEVEL_W      : BFS level width
package bfs_pkg;

  localparam int unsigned NODEID_W = 32;
  localparam int unsigned LEVEL_W  = 32;

  typedef struct packed {
    logic [NODEID_W-1:0] parent;
    logic                active;
  } node_state_t;

  localparam int unsigned NODE_STATE_W = $bits(node_state_t);

  // A node is newly visited when it had no parent and gather assigns one.
  function automatic logic is_new_visit(input logic [NODEID_W-1:0] old_parent,
                                        input logic [NODEID_W-1:0] new_parent);
    return (old_parent == '0) && (new_parent != '0);
  endfunction

endpackage

// File: rtl/bfs_state_ram.sv
// Simple dual-port node-state RAM: one write port, one registered read port.
// The read data register only updates when rd_en is high, so data holds
// between reads.
// Ports:
//   clk, rst_n            : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port, commits at the rising edge
//   rd_en/rd_addr         : read request
//   rd_data               : read data, valid the cycle after rd_en
module bfs_state_ram
  import bfs_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  node_state_t       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output node_state_t       rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  node_state_t mem_q [DEPTH];
  node_state_t rd_data_q;
  node_state_t rd_data_d;

  // Storage array; cleared by the owner's INIT sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read with hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bfs_state_stage.sv
// Per-PE BFS node-state stage. Reads the destination node's state for each
// incoming message (S1), presents message plus state to gather (S2), writes
// gather's updated state back and emits newly visited nodes. Clears the
// node-state RAM after every reset and blocks messages to nodes in flight.
// Ports:
//   sys_clk, sys_rst_n           : clock, async active-low reset
//   msg_*                        : incoming message handshake and fields
//   *_out, gather_valid          : S2 contents presented to gather
//   state_*_in, state_ack        : gather writeback and its acceptance
//   upd_*                        : newly visited node stream
//   init_done                    : RAM clear complete
//   stat_msgs, stat_visits       : counters, only with BFS_STATE_STATS_EN
module bfs_state_stage
  import bfs_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [NODEID_W-1:0] msg_nodeid,
  input  logic [NODEID_W-1:0] msg_sender,
  input  logic [LEVEL_W-1:0]  msg_level,
  output logic [LEVEL_W-1:0]  level_out,
  output logic [NODEID_W-1:0] nodeid_out,
  output logic [NODEID_W-1:0] sender_out,
  output logic [NODEID_W-1:0] state_parent_out,
  output logic                state_active_out,
  output logic                gather_valid,
  input  logic [NODEID_W-1:0] state_nodeid_in,
  input  logic [NODEID_W-1:0] state_parent_in,
  input  logic                state_active_in,
  input  logic                state_valid_in,
  output logic                state_ack,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [NODEID_W-1:0] upd_nodeid,
  output logic [NODEID_W-1:0] upd_parent,
  output logic                init_done
`ifdef BFS_STATE_STATS_EN
  ,
  output logic [31:0]         stat_msgs,
  output logic [31:0]         stat_visits
`endif
);

  localparam logic [0:0]        ST_INIT   = 1'b0;
  localparam logic [0:0]        ST_RUN    = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              init_done_q, init_done_d;

  logic                v1_q, v1_d;
  logic [NODEID_W-1:0] s1_nodeid_q, s1_nodeid_d;
  logic [NODEID_W-1:0] s1_sender_q, s1_sender_d;
  logic [LEVEL_W-1:0]  s1_level_q, s1_level_d;

  logic                v2_q, v2_d;
  logic [NODEID_W-1:0] s2_nodeid_q, s2_nodeid_d;
  logic [NODEID_W-1:0] s2_sender_q, s2_sender_d;
  logic [LEVEL_W-1:0]  s2_level_q, s2_level_d;
  logic [NODEID_W-1:0] s2_parent_q, s2_parent_d;
  logic                s2_active_q, s2_active_d;

  logic        run_c, hit_s1_c, hit_s2_c, newvis_c;
  logic        ack_c, adv12_c, ready_c, accept_c;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  node_state_t       ram_wr_data;
  node_state_t       ram_rd_data;

  // Handshake, hazard and retire conditions.
  always_comb begin
    run_c    = (state_q == ST_RUN);
    hit_s1_c = v1_q && (msg_nodeid[ADDR_W-1:0] == s1_nodeid_q[ADDR_W-1:0]);
    hit_s2_c = v2_q && (msg_nodeid[ADDR_W-1:0] == s2_nodeid_q[ADDR_W-1:0]);
    newvis_c = is_new_visit(s2_parent_q, state_parent_in);
    ack_c    = run_c && v2_q && state_valid_in && (!newvis_c || upd_ready);
    adv12_c  = v1_q && (!v2_q || ack_c);
    // S2 match holds through the retire cycle so a follower reads the written value.
    ready_c  = run_c && (!v1_q || adv12_c) && !hit_s1_c && !hit_s2_c;
    accept_c = msg_valid && ready_c;
  end

  // RAM write port is owned by the INIT sweep, then by gather writeback.
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = init_addr_q;
    ram_wr_data = '0;
    if (!run_c) begin
      ram_wr_en = 1'b1;
    end else if (ack_c) begin
      ram_wr_en          = 1'b1;
      ram_wr_addr        = s2_nodeid_q[ADDR_W-1:0];
      ram_wr_data.parent = state_parent_in;
      ram_wr_data.active = state_active_in;
    end
  end

  bfs_state_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_en   (accept_c),
    .rd_addr (msg_nodeid[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  // FSM next state and pipeline register updates.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    v1_d        = v1_q;
    s1_nodeid_d = s1_nodeid_q;
    s1_sender_d = s1_sender_q;
    s1_level_d  = s1_level_q;
    v2_d        = v2_q;
    s2_nodeid_d = s2_nodeid_q;
    s2_sender_d = s2_sender_q;
    s2_level_d  = s2_level_q;
    s2_parent_d = s2_parent_q;
    s2_active_d = s2_active_q;

    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + ADDR_W'(1);
        if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (adv12_c) begin
      v2_d        = 1'b1;
      s2_nodeid_d = s1_nodeid_q;
      s2_sender_d = s1_sender_q;
      s2_level_d  = s1_level_q;
      s2_parent_d = ram_rd_data.parent;
      s2_active_d = ram_rd_data.active;
    end else if (ack_c) begin
      v2_d = 1'b0;
    end

    if (accept_c) begin
      v1_d        = 1'b1;
      s1_nodeid_d = msg_nodeid;
      s1_sender_d = msg_sender;
      s1_level_d  = msg_level;
    end else if (adv12_c) begin
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      v1_q        <= 1'b0;
      s1_nodeid_q <= '0;
      s1_sender_q <= '0;
      s1_level_q  <= '0;
      v2_q        <= 1'b0;
      s2_nodeid_q <= '0;
      s2_sender_q <= '0;
      s2_level_q  <= '0;
      s2_parent_q <= '0;
      s2_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      v1_q        <= v1_d;
      s1_nodeid_q <= s1_nodeid_d;
      s1_sender_q <= s1_sender_d;
      s1_level_q  <= s1_level_d;
      v2_q        <= v2_d;
      s2_nodeid_q <= s2_nodeid_d;
      s2_sender_q <= s2_sender_d;
      s2_level_q  <= s2_level_d;
      s2_parent_q <= s2_parent_d;
      s2_active_q <= s2_active_d;
    end
  end

`ifdef BFS_STATE_STATS_EN
  logic [31:0] stat_msgs_q, stat_msgs_d;
  logic [31:0] stat_visits_q, stat_visits_d;

  // Free-running wrap-around event counters.
  always_comb begin
    stat_msgs_d   = stat_msgs_q;
    stat_visits_d = stat_visits_q;
    if (accept_c) begin
      stat_msgs_d = stat_msgs_q + 32'd1;
    end
    if (ack_c && newvis_c) begin
      stat_visits_d = stat_visits_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_msgs_q   <= '0;
      stat_visits_q <= '0;
    end else begin
      stat_msgs_q   <= stat_msgs_d;
      stat_visits_q <= stat_visits_d;
    end
  end

  assign stat_msgs   = stat_msgs_q;
  assign stat_visits = stat_visits_q;
`endif

  assign msg_ready        = ready_c;
  assign state_ack        = ack_c;
  assign upd_valid        = ack_c && newvis_c;
  assign upd_nodeid       = upd_valid ? state_nodeid_in : '0;
  assign upd_parent       = upd_valid ? state_parent_in : '0;
  assign gather_valid     = v2_q;
  assign level_out        = s2_level_q;
  assign nodeid_out       = s2_nodeid_q;
  assign sender_out       = s2_sender_q;
  assign state_parent_out = s2_parent_q;
  assign state_active_out = s2_active_q;
  assign init_done        = init_done_q;

endmodule
